bcd_display_scanner: RTL
========================

Name: bcd_display_scanner

Overview:
Time-multiplexed driver for a common-anode/common-cathode multi-digit seven-segment display, successor to the single-digit combinational BCD decoder.
- Takes a packed signed BCD magnitude (NUM_DIGITS digits plus sign), double-buffers it, and scans one digit position at a time at a programmable refresh rate.
- Adds leading-zero blanking, a sign slot, invalid-code indication and anti-ghosting dead time.
- Sits between the signed BCD adder/subtractor result register and the board display pins.

Parameters:
NUM_DIGITS, 3, number of BCD magnitude digits; sign uses one extra slot, so NUM_DIGITS+1 anodes
REFRESH_DIV, 50000, clocks per slot; must be >= 2
ACTIVE_LOW_SEG, 1, 1 = segment outputs active-low
ACTIVE_LOW_AN, 1, 1 = anode/digit enables active-low

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
bcd_in  input  4*NUM_DIGITS  packed magnitude; digit i at bits [4i+3:4i], digit 0 = least significant
sign_in  input  1  1 = negative
load  input  1  single-cycle strobe; captures bcd_in/sign_in into the shadow register
blank_lz  input  1  1 = enable leading-zero blanking
disp_en  input  1  0 = all segments and anodes off; scanning continues
seg  output  7  segments {a,b,c,d,e,f,g}; seg[6]=a, seg[0]=g; registered
an  output  NUM_DIGITS+1  one-hot digit enable; an[NUM_DIGITS] = sign slot; registered
frame_done  output  1  one-cycle pulse when the slot index wraps NUM_DIGITS -> 0

Behaviour:
- Reset (async assert, sync release): prescaler=0, slot=0, shadow=0, display regs=0, pending=0, frame_done=0. seg and an read OFF: all ones if active-low, else zeros.
- Prescaler: counts 0..REFRESH_DIV-1. On terminal count the slot advances 0,1,..,NUM_DIGITS,0. frame_done is asserted in the same cycle the slot wraps to 0.
- Capture:
  - load=1 copies inputs to the shadow register and sets pending. Multiple loads within a frame: last wins.
  - At the frame wrap, if pending, shadow is copied to the display regs and pending clears.
  - If load coincides with the wrap cycle, the new inputs go straight to the display regs; pending stays 0.
  - A frame never shows mixed values.
- Decode (active-high a..g, inverted when ACTIVE_LOW_SEG=1):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Codes 10-15 = "E" 1001111. Blank = 0000000. Minus = 0000001.
- Leading-zero blanking (blank_lz=1): digit i (i>=1) is blank when it and all higher digits are 0. Digit 0 is never blanked. An invalid code counts as non-zero.
- Sign slot: minus when sign=1 and magnitude non-zero; blank otherwise (negative zero shows no sign).
- Output timing:
  - seg/an are registered and reflect the current slot one cycle after the slot register changes.
  - Dead time: an is fully OFF for the first cycle of every slot, then the slot's one-hot enable for the remaining REFRESH_DIV-1 cycles.
  - seg changes only during the dead cycle.
- disp_en=0: seg and an forced OFF on the next clock. Prescaler, slot, capture and frame_done are unaffected.
- Reset mid-scan: outputs go OFF immediately (async). Scanning restarts at slot 0 with zeros displayed.

Test Plan:
1. Reset with NUM_DIGITS=3, REFRESH_DIV=4, active-low -> seg=7'h7F, an=4'hF, frame_done=0 until the first wrap at cycle 16.
2. load bcd_in=12'h123, sign_in=0 -> from the next frame: an sequence 1110/1101/1011/0111, each 1 dead cycle (1111) + 3 active. seg=~1111001, ~1101101, ~0110000, then 7'h7F for the sign slot. frame_done pulses every 16 cycles.
3. blank_lz=1, load 12'h007, sign=1 -> slots 2,1 blank, slot 0 "7", sign slot minus (seg=7'h7E). Then load 12'h000, sign=1 -> slot 0 "0", sign blank.
4. load 12'h1A5 -> slot 1 shows "E" (seg=~1001111). With blank_lz=1 slot 2 still shows "1".
5. Two loads mid-frame (0x111 then 0x222) -> display unchanged until the wrap, then 0x222. A load on the wrap cycle takes effect in that same frame.
6. Assert rst_n mid-slot 2 -> seg/an OFF within the same cycle. After release, scan restarts at slot 0. disp_en=0 for 20 cycles -> seg/an OFF while frame_done keeps pulsing.

Source files
------------

// File: rtl/bcd_display_scanner.sv
// Multiplexed seven-segment scanner for a signed packed-BCD value. The input is
// double-buffered so a frame never mixes values. Output includes blanking and dead time.
module bcd_display_scanner #(
  parameter int NUM_DIGITS     = 3,
  parameter int REFRESH_DIV    = 50000,
  parameter bit ACTIVE_LOW_SEG = 1'b1,
  parameter bit ACTIVE_LOW_AN  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    sign_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    disp_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS:0]     an,
  output logic                    frame_done
);

  localparam int CNT_W  = $clog2(REFRESH_DIV);
  localparam int SLOT_W = $clog2(NUM_DIGITS + 1);
  localparam int BCD_W  = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS);
  // XOR masks: the OFF pattern equals the polarity mask in both polarities.
  localparam logic [6:0]          SEG_OFF = {7{ACTIVE_LOW_SEG}};
  localparam logic [NUM_DIGITS:0] AN_OFF  = {(NUM_DIGITS + 1){ACTIVE_LOW_AN}};

  logic [CNT_W-1:0]  cnt;
  logic [SLOT_W-1:0] slot;
  logic [BCD_W-1:0]  shadow_bcd;
  logic              shadow_sign;
  logic              pending;
  logic [BCD_W-1:0]  disp_bcd;
  logic              disp_sign;
  logic [6:0]        seg_cur;

  logic                  tick;
  logic                  wrap;
  logic [6:0]            sym;
  logic [3:0]            digit;
  logic [BCD_W-1:0]      upper;
  logic [NUM_DIGITS:0]   onehot;

  assign tick   = (cnt == CNT_LAST);
  assign wrap   = tick && (slot == SLOT_LAST);
  assign onehot = (NUM_DIGITS + 1)'(1) << slot;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1111110;
      4'd1:    seg_of = 7'b0110000;
      4'd2:    seg_of = 7'b1101101;
      4'd3:    seg_of = 7'b1111001;
      4'd4:    seg_of = 7'b0110011;
      4'd5:    seg_of = 7'b1011011;
      4'd6:    seg_of = 7'b1011111;
      4'd7:    seg_of = 7'b1110000;
      4'd8:    seg_of = 7'b1111111;
      4'd9:    seg_of = 7'b1111011;
      default: seg_of = 7'b1001111;
    endcase
  endfunction

  // Active-high symbol for the current slot; invalid nibbles count as non-zero.
  always_comb begin
    sym   = 7'b0000000;
    digit = 4'd0;
    upper = '0;
    if (slot == SLOT_LAST) begin
      if (disp_sign && (|disp_bcd)) sym = 7'b0000001;
    end else begin
      digit = disp_bcd[4*int'(slot) +: 4];
      upper = disp_bcd >> (4 * int'(slot));
      if (!(blank_lz && (slot != '0) && (upper == '0))) sym = seg_of(digit);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      slot        <= '0;
      shadow_bcd  <= '0;
      shadow_sign <= 1'b0;
      pending     <= 1'b0;
      disp_bcd    <= '0;
      disp_sign   <= 1'b0;
      seg_cur     <= SEG_OFF;
      seg         <= SEG_OFF;
      an          <= AN_OFF;
      frame_done  <= 1'b0;
    end else begin
      if (tick) begin
        cnt  <= '0;
        slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      frame_done <= wrap;

      // A load on the wrap cycle bypasses the shadow so it lands in the new frame.
      if (wrap) begin
        if (load) begin
          disp_bcd    <= bcd_in;
          disp_sign   <= sign_in;
          shadow_bcd  <= bcd_in;
          shadow_sign <= sign_in;
          pending     <= 1'b0;
        end else if (pending) begin
          disp_bcd  <= shadow_bcd;
          disp_sign <= shadow_sign;
          pending   <= 1'b0;
        end
      end else if (load) begin
        shadow_bcd  <= bcd_in;
        shadow_sign <= sign_in;
        pending     <= 1'b1;
      end

      // Segments latch only in the dead cycle (cnt==0) so they never switch under a lit anode.
      if (cnt == '0) seg_cur <= sym ^ SEG_OFF;

      if (!disp_en) begin
        seg <= SEG_OFF;
        an  <= AN_OFF;
      end else if (cnt == '0) begin
        seg <= sym ^ SEG_OFF;
        an  <= AN_OFF;
      end else begin
        seg <= seg_cur;
        an  <= onehot ^ AN_OFF;
      end
    end
  end

endmodule
